// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the write-back scheduler: icodes, register
// constants, scheduler state encoding and the register-write request struct.
package y86_pkg;

    localparam int WB_DATA_W = 64;
    localparam int WB_ADDR_W = 4;

    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [WB_ADDR_W-1:0] REG_NONE = 4'hF;
    localparam logic [WB_ADDR_W-1:0] RSP_IDX  = 4'h4;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WR1  = 2'd1,
        WB_WR2  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                 en;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational decode of a completed instruction into up to two ordered
// register writes. WB_POPRSP_COLLAPSE_EN folds popq %rsp into one write.
module wb_decode
    import y86_pkg::*;
#(
    parameter logic [3:0] SP_IDX = RSP_IDX
) (
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [63:0] val_e,
    input  logic [63:0] val_m,
    output wr_req_t     w0,
    output wr_req_t     w1
);

    wr_req_t w0_raw;
    wr_req_t w1_raw;

    always_comb begin
        w0_raw = '0;
        w1_raw = '0;
        case (icode)
            I_CMOVXX: if (cnd) w0_raw = '{en: 1'b1, addr: rb, data: val_e};
            I_IRMOVQ,
            I_OPQ:    w0_raw = '{en: 1'b1, addr: rb, data: val_e};
            I_MRMOVQ: w0_raw = '{en: 1'b1, addr: ra, data: val_m};
            I_CALL,
            I_RET,
            I_PUSHQ:  w0_raw = '{en: 1'b1, addr: SP_IDX, data: val_e};
            I_POPQ: begin
`ifdef WB_POPRSP_COLLAPSE_EN
                if (ra == SP_IDX) begin
                    w0_raw = '{en: 1'b1, addr: SP_IDX, data: val_m};
                end else begin
                    w0_raw = '{en: 1'b1, addr: SP_IDX, data: val_e};
                    w1_raw = '{en: 1'b1, addr: ra, data: val_m};
                end
`else
                w0_raw = '{en: 1'b1, addr: SP_IDX, data: val_e};
                w1_raw = '{en: 1'b1, addr: ra, data: val_m};
`endif
            end
            default: ;
        endcase
    end

    // A write aimed at the "no register" index never reaches the port.
    always_comb begin
        w0 = w0_raw;
        w1 = w1_raw;
        if (w0_raw.addr == REG_NONE) w0.en = 1'b0;
        if (w1_raw.addr == REG_NONE) w1.en = 1'b0;
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Sequences Y86-64 write-back and host writes onto the single register-file
// write port. Optional macro WB_POPRSP_COLLAPSE_EN (see wb_decode).
module regfile_wb_scheduler #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 4,
    parameter int RSP_IDX      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [ADDR_W-1:0] rA,
    input  logic [ADDR_W-1:0] rB,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              host_wr_valid,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wb_done
);
    import y86_pkg::*;

    wb_state_t         state_q, state_d;
    wr_req_t           pend_q, pend_d;
    logic [7:0]        starve_q, starve_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wb_done_q, wb_done_d;

    wr_req_t dec_w0, dec_w1, first_w, second_w, host_req;
    logic    slot_free, starved, accept, second_pending, host_grant;

    wb_decode #(
        .SP_IDX (4'(RSP_IDX))
    ) u_decode (
        .icode (icode),
        .cnd   (cnd),
        .ra    (rA),
        .rb    (rB),
        .val_e (valE),
        .val_m (valM),
        .w0    (dec_w0),
        .w1    (dec_w1)
    );

    // Compact the decoded pair so the first surviving write always goes first.
    always_comb begin
        first_w  = dec_w0.en ? dec_w0 : dec_w1;
        second_w = (dec_w0.en && dec_w1.en) ? dec_w1 : '0;
        host_req = '{en: (host_wr_addr != REG_NONE), addr: host_wr_addr, data: host_wr_data};
    end

    assign second_pending = (state_q == WB_WR1) && pend_q.en;
    assign slot_free      = (state_q == WB_IDLE) || (state_q == WB_WR2) || !second_pending;
    assign starved        = (starve_q == 8'(STARVE_LIMIT));
    assign in_ready       = slot_free && !starved;
    assign accept         = in_valid && in_ready;
    assign host_grant     = rst_n && host_wr_valid && !accept && !second_pending;
    assign host_wr_ready  = host_grant;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        starve_d  = starve_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wb_done_d = 1'b0;

        if (accept) begin
            pend_d    = second_w;
            wb_done_d = !second_w.en;
            state_d   = first_w.en ? WB_WR1 : WB_IDLE;
            wr_en_d   = first_w.en;
            if (first_w.en) begin
                wr_addr_d = first_w.addr;
                wr_data_d = first_w.data;
            end
        end else if (host_grant) begin
            state_d = WB_IDLE;
            pend_d  = '0;
            wr_en_d = host_req.en;
            if (host_req.en) begin
                wr_addr_d = host_req.addr;
                wr_data_d = host_req.data;
            end
        end else if (second_pending) begin
            state_d   = WB_WR2;
            pend_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = pend_q.addr;
            wr_data_d = pend_q.data;
            wb_done_d = 1'b1;
        end else begin
            state_d = WB_IDLE;
        end

        // Waiting host requests age until they force a slot; a grant resets the age.
        if (host_grant) begin
            starve_d = '0;
        end else if (host_wr_valid && !starved) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_IDLE;
            pend_q    <= '0;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wb_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wb_done_q <= wb_done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wb_done = wb_done_q;

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences Y86-64 write-back onto the single write port of the 15×64 register file.
- Decodes each completed instruction (icode, cnd, rA, rB, valE, valM) into zero, one or two register writes. Issues them one per cycle, in architectural order.
- Shares the port with a host/loader write channel, using pipeline priority plus a starvation guard.
- Sits between the execute/memory stages and the register file. `in_ready` back-pressures the sequencer.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 4, register index width; index 4'hF = "no register"
- RSP_IDX, 4, stack pointer index
- STARVE_LIMIT, 8, host wait cycles before the host is forced a slot (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  write-back request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- icode  in  4  instruction code
- cnd  in  1  condition flag (cmovXX)
- rA  in  ADDR_W  register A index
- rB  in  ADDR_W  register B index
- valE  in  DATA_W  ALU result
- valM  in  DATA_W  memory result
- host_wr_valid  in  1  host write request
- host_wr_addr  in  ADDR_W  host write index
- host_wr_data  in  DATA_W  host write data
- host_wr_ready  out  1  host request accepted this cycle
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  ADDR_W  write index (registered)
- wr_data  out  DATA_W  write data (registered)
- wb_done  out  1  one-cycle pulse: all writes of an accepted instruction issued

Behaviour:
- Reset state: wr_en=0, wr_addr=0, wr_data=0, wb_done=0, host_wr_ready=0, state=IDLE, starve_cnt=0, pending latches cleared.
- Decode, in architectural order; the first write listed goes first:
  - icode 2 (cmovXX): rB<-valE, only when cnd=1.
  - icode 3 (irmovq) and 6 (OPq): rB<-valE.
  - icode 5 (mrmovq): rA<-valM.
  - icode 8, 9, A (call, ret, pushq): RSP_IDX<-valE.
  - icode B (popq): RSP_IDX<-valE, then rA<-valM.
  - All other icodes: no write.
  - Any write whose index is 4'hF is dropped.
- State machine:
  - States: IDLE, WR1, WR2.
  - IDLE, in_ready=1 unless the host is starved.
  - On acceptance at cycle T:
    - If 2 writes: write 1 is driven at T+1 (WR1), write 2 at T+2 (WR2), wb_done=1 with write 2.
    - If 1 write: driven at T+1 (WR1), wb_done=1 at T+1.
    - If 0 writes: wb_done=1 at T+1, wr_en=0, state stays IDLE.
  - in_ready=1 in the last write cycle (WR1 with no second write, or WR2), giving back-to-back throughput. in_ready=0 in WR1 when a second write is pending.
- Host arbitration:
  - host_wr_ready=1 in a cycle when host_wr_valid=1 and no pipeline request is accepted or pending.
  - The host write is driven on the port the next cycle; wb_done is not asserted for it.
  - starve_cnt increments each cycle host_wr_valid=1 && host_wr_ready=0, saturating at STARVE_LIMIT. It clears on a host grant.
  - When starve_cnt==STARVE_LIMIT, in_ready is forced 0 at the next slot and the host is granted. In-flight pipeline writes are never split or preempted.
- Same-destination writes (popq %rsp): both are issued in order, so valM is the final value.
- Simultaneous in_valid and host_wr_valid when not starved: the pipeline wins.
- Reset mid-operation: pending writes are discarded, no wb_done is emitted, and outputs return to reset values immediately.
- wr_en is never asserted without a decoded or host write. wr_addr is never 4'hF while wr_en=1.

Optional Feature:
- Macro: WB_POPRSP_COLLAPSE_EN.
- Defined: popq with rA==RSP_IDX issues only the single write RSP_IDX<-valM. wb_done follows at T+1 and the instruction occupies one cycle.
- Undefined: both writes are issued as specified above (two cycles, same final value).

Decomposition:
- Shared package `y86_pkg`:
  - icode constants (I_CMOVXX, I_IRMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ)
  - REG_NONE=4'hF, RSP_IDX
  - wb_state_t enum
  - a write-request struct (en, addr, data)
- One sub-module: `wb_decode`, combinational. It maps an instruction to two write-request structs. The scheduler holds all sequential logic.

Test Plan:
1. Reset release, then irmovq (icode 3, rB=2, valE=0x10): wr_en at T+1 with addr 2, data 0x10; wb_done at T+1; in_ready stays 1.
2. popq (rA=3, valE=0x200, valM=0xAB): T+1 writes 4<-0x200, T+2 writes 3<-0xAB; in_ready=0 at T+1; wb_done at T+2.
3. cmovXX with cnd=0, then cnd=1 (rB=5, valE=7): first instruction produces no write and wb_done at T+1; second writes 5<-7.
4. Continuous in_valid plus host_wr_valid (addr 6, data 0x55) held: host_wr_ready asserts after exactly STARVE_LIMIT=8 wait cycles; the next port write is 6<-0x55.
5. popq %rsp (rA=4, valE=0x100, valM=0x300):
   - Macro off: two writes, final 4<-0x300.
   - Macro on: one write 4<-0x300.
6. rst_n low during WR1 of popq: outputs clear asynchronously; after release, no WR2 write and no wb_done.
